// File: rtl/gshare_pkg.sv
// Shared types and constants for the gshare branch predictor: counter
// encoding, table/history width and controller states.
package gshare_pkg;

    localparam int GHR_WIDTH = 8;

    typedef enum logic [1:0] {
        CNT_SN = 2'b00,
        CNT_WN = 2'b01,
        CNT_WT = 2'b10,
        CNT_ST = 2'b11
    } counter_t;

    localparam counter_t CNT_INIT = CNT_WN;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic counter_t cnt_update(input counter_t cnt, input logic taken);
        logic [1:0] v;
        v = cnt;
        if (taken && (cnt != CNT_ST)) begin
            v = v + 2'd1;
        end else if (!taken && (cnt != CNT_SN)) begin
            v = v - 2'd1;
        end
        return counter_t'(v);
    endfunction

endpackage

// File: rtl/gshare_sram.sv
// Two-port pattern table: port 0 writes, port 1 reads; chip selects active-low.
// A write is captured on one edge and lands in the array on the next edge.
module gshare_sram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 2
) (
    input  logic              clk0,
    input  logic              csb0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] din0,
    input  logic              clk1,
    input  logic              csb1,
    input  logic [ADDR_W-1:0] addr1,
    output logic [DATA_W-1:0] dout1
);

    // NOTE: the array has no reset; the INIT sweep gives every entry a defined value.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              wr_pend;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk0) begin
        wr_pend <= ~csb0;
        wr_addr <= addr0;
        wr_data <= din0;
        if (wr_pend) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk1) begin
        if (!csb1) begin
            rd_addr <= addr1;
        end
    end

    // Read address is registered; data follows the array, so a write that
    // committed on the same edge as the read capture is already visible.
    assign dout1 = mem[rd_addr];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor global history indexes a table of 2-bit
// counters; the requester checkpoints history/counter and returns them on update.
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int GHR_W = GHR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    output logic             resp_valid,
    output logic             resp_taken,
    output logic [1:0]       resp_counter,
    output logic [GHR_W-1:0] resp_ghr,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic [1:0]       upd_counter,
    input  logic             upd_taken,
    input  logic             upd_mispredict
);

    state_t           state;
    logic [GHR_W-1:0] init_idx;
    logic [GHR_W-1:0] ghr;
    logic [GHR_W-1:0] resp_ghr_q;
    logic             resp_valid_q;
    logic             byp_q;
    counter_t         byp_cnt_q;

    logic             pred_acc;
    logic             upd_acc;
    logic             init_wr;
    logic [GHR_W-1:0] pred_idx;
    logic [GHR_W-1:0] upd_idx;
    logic [GHR_W-1:0] wr_addr;
    counter_t         upd_next;
    counter_t         wr_data;
    logic [1:0]       rd_data;
    logic             unused_pc_bits;

    assign ready    = (state == ST_RUN);
    assign pred_acc = pred_valid && ready;
    assign upd_acc  = upd_valid && ready;
    assign init_wr  = (state == ST_INIT);

    assign pred_idx = pred_pc[GHR_W+1:2] ^ ghr;
    assign upd_idx  = upd_pc[GHR_W+1:2] ^ upd_ghr;
    assign upd_next = cnt_update(counter_t'(upd_counter), upd_taken);
    assign wr_addr  = init_wr ? init_idx : upd_idx;
    assign wr_data  = init_wr ? CNT_INIT : upd_next;

    assign unused_pc_bits = ^{pred_pc[31:GHR_W+2], pred_pc[1:0],
                              upd_pc[31:GHR_W+2], upd_pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else if (state == ST_INIT) begin
            if (&init_idx) begin
                state <= ST_RUN;
            end
            init_idx <= init_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_ghr_q   <= '0;
            byp_q        <= 1'b0;
            byp_cnt_q    <= CNT_SN;
            ghr          <= '0;
        end else begin
            resp_valid_q <= pred_acc;
            if (pred_acc) begin
                resp_ghr_q <= ghr;
                // The table commits this update too late for this read.
                byp_q      <= upd_acc && (upd_idx == pred_idx);
                byp_cnt_q  <= upd_next;
            end
            if (upd_acc && upd_mispredict) begin
                ghr <= {upd_ghr[GHR_W-2:0], upd_taken};
            end else if (resp_valid_q) begin
                ghr <= {ghr[GHR_W-2:0], resp_taken};
            end
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_counter = resp_valid_q ? (byp_q ? byp_cnt_q : rd_data) : 2'b00;
    assign resp_taken   = resp_counter[1];
    assign resp_ghr     = resp_valid_q ? resp_ghr_q : '0;

    gshare_sram #(
        .ADDR_W (GHR_W),
        .DATA_W (2)
    ) u_sram (
        .clk0  (clk),
        .csb0  (~(init_wr || upd_acc)),
        .addr0 (wr_addr),
        .din0  (wr_data),
        .clk1  (clk),
        .csb1  (~pred_acc),
        .addr1 (pred_idx),
        .dout1 (rd_data)
    );

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: init sweep timing, counter training and
// saturation, same-cycle bypass, speculative/recovered history and mid-INIT reset.
module tb_gshare_predictor;

    localparam int GHR_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             ready;
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             resp_valid;
    logic             resp_taken;
    logic [1:0]       resp_counter;
    logic [GHR_W-1:0] resp_ghr;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [GHR_W-1:0] upd_ghr;
    logic [1:0]       upd_counter;
    logic             upd_taken;
    logic             upd_mispredict;

    always #5 clk = ~clk;

    gshare_predictor #(.GHR_W(GHR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ready          (ready),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .resp_valid     (resp_valid),
        .resp_taken     (resp_taken),
        .resp_counter   (resp_counter),
        .resp_ghr       (resp_ghr),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_ghr        (upd_ghr),
        .upd_counter    (upd_counter),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict)
    );

    int n_checks = 0;
    int n_errs   = 0;

    logic             r_valid;
    logic             r_taken;
    logic [1:0]       r_cnt;
    logic [GHR_W-1:0] r_ghr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic capture_resp();
        r_valid = resp_valid;
        r_taken = resp_taken;
        r_cnt   = resp_counter;
        r_ghr   = resp_ghr;
    endtask

    // Request at one negedge, sample the response at the next.
    task automatic predict(input logic [31:0] pc);
        @(negedge clk);
        pred_valid = 1'b1;
        pred_pc    = pc;
        @(negedge clk);
        pred_valid = 1'b0;
        capture_resp();
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic [GHR_W-1:0] g,
                             input logic [1:0] c, input logic t, input logic m);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_ghr        = g;
        upd_counter    = c;
        upd_taken      = t;
        upd_mispredict = m;
    endtask

    task automatic update(input logic [31:0] pc, input logic [GHR_W-1:0] g,
                          input logic [1:0] c, input logic t, input logic m);
        @(negedge clk);
        drive_upd(pc, g, c, t, m);
        @(negedge clk);
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [1:0] cnt, input logic [GHR_W-1:0] g);
        check({tag, "_valid"}, 32'(r_valid), 32'd1);
        check({tag, "_cnt"},   32'(r_cnt),   32'(cnt));
        check({tag, "_taken"}, 32'(r_taken), 32'(cnt[1]));
        check({tag, "_ghr"},   32'(r_ghr),   32'(g));
    endtask

    // Counts edges after reset release until ready is seen; bounded.
    task automatic wait_ready(output int edges, output logic saw_resp);
        edges    = 0;
        saw_resp = 1'b0;
        while (edges < 400) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
            if (ready) break;
        end
        pred_valid = 1'b0;
    endtask

    int   edges;
    logic saw_resp;

    initial begin
        rst = 1'b1;
        pred_valid = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_counter = '0;
        upd_taken = 1'b0; upd_mispredict = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready",      32'(ready),        32'd0);
        check("rst_resp_valid", 32'(resp_valid),   32'd0);
        check("rst_resp_cnt",   32'(resp_counter), 32'd0);
        check("rst_resp_ghr",   32'(resp_ghr),     32'd0);

        // Init sweep: 256 write cycles, ready in cycle 257.
        rst = 1'b0;
        wait_ready(edges, saw_resp);
        check("init_cycles_to_ready", 32'(edges), 32'd256);

        predict(32'h100);
        expect_resp("first_pred", 2'b01, 8'h00);

        // Train index 0x10 to strongly taken; saturation at 11.
        update(32'h40, 8'h00, 2'b01, 1'b1, 1'b0);
        update(32'h40, 8'h00, 2'b10, 1'b1, 1'b0);
        update(32'h40, 8'h00, 2'b11, 1'b1, 1'b0);
        predict(32'h40);
        expect_resp("trained", 2'b11, 8'h00);
        @(negedge clk);
        check("idle_resp_cnt", 32'(resp_counter), 32'd0);
        check("idle_resp_ghr", 32'(resp_ghr),     32'd0);
        update(32'h40, 8'h00, 2'b11, 1'b1, 1'b0);
        predict(32'h44);
        expect_resp("sat_high", 2'b11, 8'h01);

        // Saturation at 00, plus recovery back to history 0.
        update(32'h3FC, 8'h00, 2'b00, 1'b0, 1'b1);
        predict(32'h3FC);
        expect_resp("sat_low", 2'b00, 8'h00);

        // Same-cycle update and predict on one index: bypass.
        @(negedge clk);
        drive_upd(32'h80, 8'h00, 2'b01, 1'b1, 1'b0);
        pred_valid = 1'b1;
        pred_pc    = 32'h80;
        @(negedge clk);
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        capture_resp();
        expect_resp("bypass", 2'b10, 8'h00);
        predict(32'h84);
        expect_resp("bypass_committed", 2'b10, 8'h01);

        // Same-cycle update on a different index must not bypass.
        @(negedge clk);
        drive_upd(32'hC0, 8'h00, 2'b01, 1'b1, 1'b0);
        pred_valid = 1'b1;
        pred_pc    = 32'h80;
        @(negedge clk);
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        capture_resp();
        expect_resp("no_bypass", 2'b01, 8'h03);

        // Speculative history: four taken predicts from GHR 0.
        update(32'h3FC, 8'h00, 2'b00, 1'b0, 1'b1);
        predict(32'h40);
        expect_resp("spec0", 2'b11, 8'h00);
        predict(32'h44);
        expect_resp("spec1", 2'b11, 8'h01);
        predict(32'h4C);
        expect_resp("spec2", 2'b11, 8'h03);
        predict(32'h5C);
        expect_resp("spec3", 2'b11, 8'h07);
        predict(32'h0);
        expect_resp("spec_ghr_0f", 2'b01, 8'h0F);

        // Mispredict recovery.
        update(32'h3FC, 8'h01, 2'b01, 1'b0, 1'b1);
        predict(32'h0);
        expect_resp("recover_ghr_02", 2'b01, 8'h02);

        // Recovery in the response cycle wins over the speculative shift.
        @(negedge clk);
        pred_valid = 1'b1;
        pred_pc    = 32'h40;
        @(negedge clk);
        pred_valid = 1'b0;
        capture_resp();
        drive_upd(32'h3FC, 8'h10, 2'b01, 1'b1, 1'b1);
        @(negedge clk);
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        expect_resp("override_resp", 2'b01, 8'h04);
        predict(32'h0);
        expect_resp("override_ghr", 2'b01, 8'h21);

        // Reset in RUN with a same-cycle request: no response.
        @(negedge clk);
        rst        = 1'b1;
        pred_valid = 1'b1;
        pred_pc    = 32'h40;
        @(negedge clk);
        check("rst_run_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_run_ready",      32'(ready),      32'd0);

        // Reset again at INIT index 100, request held high throughout INIT.
        rst = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("mid_init_ready", 32'(ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready(edges, saw_resp);
        check("reinit_cycles_to_ready", 32'(edges),    32'd256);
        check("init_pred_ignored",      32'(saw_resp), 32'd0);
        predict(32'h40);
        expect_resp("reinit_table", 2'b01, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule
